// File: rtl/console_input_pkg.sv
// Shared constants for the console input front end: button/switch bit map and defaults.
package console_input_pkg;

  localparam int BTN_RESET  = 0;
  localparam int BTN_FIRE   = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 4;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 6;

  localparam int SW_DIFF0 = 0;
  localparam int SW_DIFF1 = 1;
  localparam int SW_COLOR = 2;
  localparam int SW_PAL   = 3;

  localparam int         DEF_DB_TICKS = 8;
  localparam logic [3:0] DEF_SW_INIT  = 4'b0100;

endpackage

// File: rtl/debounce_cell.sv
// One input bit: multi-flop synchroniser followed by a tick-counted debouncer.
module debounce_cell #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_TICKS    = 8,
  parameter int DB_W        = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic state_o,
  output logic rise_o
);

  localparam logic [DB_W-1:0] LAST_CNT = DB_W'(DB_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt_q;
  logic                   st_q;
  logic                   st_d_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after DB_TICKS ticks of continuous disagreement;
  // any return to the current state restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      st_q   <= 1'b0;
      st_d_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      st_d_q <= st_q;
      if (sync_bit == st_q) begin
        cnt_q <= '0;
      end else if (tick_i) begin
        if (cnt_q == LAST_CNT) begin
          st_q  <= sync_bit;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign state_o = st_q;
  assign rise_o  = st_q & ~st_d_q;

endmodule

// File: rtl/console_input_conditioner.sv
// Debounces joystick/console buttons and turns momentary console keys into latched
// toggle switches; all outputs are registered in PIA polarity.
module console_input_conditioner
  import console_input_pkg::*;
#(
  parameter int              N_BTN       = 7,
  parameter int              N_SW        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              DB_TICKS    = DEF_DB_TICKS,
  parameter int              DB_W        = 4,
  parameter logic [N_SW-1:0] SW_INIT     = DEF_SW_INIT,
  parameter bit              BLOCK_OPP   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [N_BTN-1:0] raw_btn_i,
  input  logic [N_SW-1:0]  raw_key_i,
  output logic [N_BTN-1:0] buttons_o,
  output logic [N_SW-1:0]  sw_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [7:0]       diag_o
);

  logic [N_BTN-1:0] btn_st;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_mask;
  logic [N_SW-1:0]  key_st;
  logic [N_SW-1:0]  key_rise;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_TICKS   (DB_TICKS),
      .DB_W       (DB_W)
    ) u_db (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_i (tick_i),
      .raw_i  (raw_btn_i[i]),
      .state_o(btn_st[i]),
      .rise_o (btn_rise[i])
    );
  end

  for (genvar k = 0; k < N_SW; k++) begin : g_key
    debounce_cell #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_TICKS   (DB_TICKS),
      .DB_W       (DB_W)
    ) u_db (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_i (tick_i),
      .raw_i  (raw_key_i[k]),
      .state_o(key_st[k]),
      .rise_o (key_rise[k])
    );
  end

  // Opposing directions held together read as neither; press pulses stay unmasked.
  always_comb begin
    btn_mask = btn_st;
    if (BLOCK_OPP && btn_st[BTN_UP] && btn_st[BTN_DOWN]) begin
      btn_mask[BTN_UP]   = 1'b0;
      btn_mask[BTN_DOWN] = 1'b0;
    end
    if (BLOCK_OPP && btn_st[BTN_LEFT] && btn_st[BTN_RIGHT]) begin
      btn_mask[BTN_LEFT]  = 1'b0;
      btn_mask[BTN_RIGHT] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buttons_o   <= '1;
      sw_o        <= SW_INIT;
      btn_press_o <= '0;
    end else begin
      buttons_o   <= ~btn_mask;
      sw_o        <= sw_o ^ key_rise;
      btn_press_o <= btn_rise;
    end
  end

  assign diag_o = {key_st[3:0], sw_o[3:0]};

endmodule

// File: tb/tb_console_input_conditioner.sv
// Directed bench for console_input_conditioner: expected output events (value and cycle)
// are queued by the stimulus and consumed by an output-change monitor.
module tb_console_input_conditioner;
  import console_input_pkg::*;

  localparam int W = 50;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       tick_i;
  logic [6:0] raw_btn_i;
  logic [3:0] raw_key_i;
  logic [6:0] buttons_o;
  logic [3:0] sw_o;
  logic [6:0] btn_press_o;
  logic [7:0] diag_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n;
  bit mon_en = 1'b0;

  logic [W-1:0]  exp_q[$];
  logic [17:0]   prev_v;
  logic [17:0]   cur_v;
  logic [W-1:0]  e;

  console_input_conditioner dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .tick_i     (tick_i),
    .raw_btn_i  (raw_btn_i),
    .raw_key_i  (raw_key_i),
    .buttons_o  (buttons_o),
    .sw_o       (sw_o),
    .btn_press_o(btn_press_o),
    .diag_o     (diag_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Every input change happens here, on the falling edge; tick every 4th clock.
  task automatic step();
    @(negedge clk);
    cyc++;
    tick_i = (cyc % 4 == 0);
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  // Cycle index of the first tick the debouncer can see for a raw change made at negedge c.
  function automatic int first_tick(input int c);
    int m;
    m = c + 2;
    while (m % 4 != 0) m++;
    return m;
  endfunction

  // Output settles one clk after the 8th counted tick.
  function automatic int out_cyc(input int c);
    return first_tick(c) + 28 + 1;
  endfunction

  task automatic push_exp(input int at, input logic [6:0] b, input logic [3:0] s,
                          input logic [6:0] p);
    exp_q.push_back({at[31:0], b, s, p});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // scoreboard monitor: any change of {buttons, sw, press} must match the queue head
  always @(posedge clk) begin
    #2;
    cur_v = {buttons_o, sw_o, btn_press_o};
    if (mon_en && cur_v !== prev_v) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got out=%h at cyc %0d, required no change", cur_v, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e[17:0] !== cur_v || e[49:18] != cyc) begin
          errors++;
          $display("FAIL event: got out=%h at cyc %0d, required out=%h at cyc %0d",
                   cur_v, cyc, e[17:0], e[49:18]);
        end
      end
    end
    prev_v = cur_v;
  end

  initial begin
    rst_i     = 1'b1;
    tick_i    = 1'b0;
    raw_btn_i = '1;
    raw_key_i = '1;
    run(4);
    chk("reset_buttons", 32'(buttons_o), 32'h7F);
    chk("reset_sw", 32'(sw_o), 32'h4);
    chk("reset_press", 32'(btn_press_o), 32'h0);
    chk("reset_diag", 32'(diag_o), 32'h04);
    mon_en = 1'b1;

    // all inputs held through reset: presses, opposing pairs masked, every key toggles once
    rst_i = 1'b0;
    n = cyc;
    push_exp(out_cyc(n), 7'h78, 4'b1011, 7'h7F);
    push_exp(out_cyc(n) + 1, 7'h78, 4'b1011, 7'h00);
    run(45);
    raw_btn_i = '0;
    raw_key_i = '0;
    n = cyc;
    push_exp(out_cyc(n), 7'h7F, 4'b1011, 7'h00);
    run(45);

    // reset restores the switch defaults
    rst_i = 1'b1;
    push_exp(cyc, 7'h7F, 4'b0100, 7'h00);
    run(6);
    rst_i = 1'b0;
    run(10);

    // colour key: long press toggles once, release does nothing, second press toggles back
    raw_key_i[SW_COLOR] = 1'b1;
    push_exp(out_cyc(cyc), 7'h7F, 4'b0000, 7'h00);
    run(400);
    raw_key_i[SW_COLOR] = 1'b0;
    run(45);
    raw_key_i[SW_COLOR] = 1'b1;
    push_exp(out_cyc(cyc), 7'h7F, 4'b0100, 7'h00);
    run(45);
    raw_key_i[SW_COLOR] = 1'b0;
    run(45);

    // fire press and release
    raw_btn_i[BTN_FIRE] = 1'b1;
    n = cyc;
    push_exp(out_cyc(n), 7'h7D, 4'b0100, 7'h02);
    push_exp(out_cyc(n) + 1, 7'h7D, 4'b0100, 7'h00);
    run(60);
    raw_btn_i[BTN_FIRE] = 1'b0;
    push_exp(out_cyc(cyc), 7'h7F, 4'b0100, 7'h00);
    run(45);

    // right: a 7-tick pulse and 3-tick chatter never get through
    raw_btn_i[BTN_RIGHT] = 1'b1;
    run(28);
    raw_btn_i[BTN_RIGHT] = 1'b0;
    run(10);
    for (int i = 0; i < 3; i++) begin
      raw_btn_i[BTN_RIGHT] = 1'b1;
      run(12);
      raw_btn_i[BTN_RIGHT] = 1'b0;
      run(4);
    end
    run(45);

    // up+down together are masked but still pulse; releasing down exposes up
    raw_btn_i[BTN_DOWN:BTN_UP] = 2'b11;
    n = cyc;
    push_exp(out_cyc(n), 7'h7F, 4'b0100, 7'h18);
    push_exp(out_cyc(n) + 1, 7'h7F, 4'b0100, 7'h00);
    run(60);
    raw_btn_i[BTN_DOWN] = 1'b0;
    push_exp(out_cyc(cyc), 7'h77, 4'b0100, 7'h00);
    run(45);
    raw_btn_i[BTN_UP] = 1'b0;
    push_exp(out_cyc(cyc), 7'h7F, 4'b0100, 7'h00);
    run(45);

    // difficulty 0 toggle, then PAL key interrupted by reset and re-timed from zero
    raw_key_i[SW_DIFF0] = 1'b1;
    push_exp(out_cyc(cyc), 7'h7F, 4'b0101, 7'h00);
    run(45);
    raw_key_i[SW_DIFF0] = 1'b0;
    run(45);
    raw_key_i[SW_PAL] = 1'b1;
    run(22);
    rst_i = 1'b1;
    push_exp(cyc, 7'h7F, 4'b0100, 7'h00);
    run(6);
    rst_i = 1'b0;
    push_exp(out_cyc(cyc), 7'h7F, 4'b1100, 7'h00);
    run(45);
    chk("diag_pal_held", 32'(diag_o), 32'h8C);
    raw_key_i[SW_PAL] = 1'b0;
    run(45);

    for (int g = 0; g < 200 && exp_q.size() != 0; g++) step();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: got none, required out=%h at cyc %0d", e[17:0], e[49:18]);
    end
    run(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
